des_lfsr_keygen: RTL and testbench

LFSR-based round-key generator that sits directly upstream of the DES core's round-key storage. On a load request it derives a 48-bit seed from a 64-bit user key and steps a maximal-length 48-bit LFSR. It writes NUM_KEYS round keys into the storage RAM through a single write port. The DES core may only be started after `keys_ready` is high.

---
 rtl/des_lfsr_keygen_if.sv | 52 +++++
 rtl/des_lfsr_keygen.sv | 175 +++++++++++++++++
 tb/tb_des_lfsr_keygen.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/des_lfsr_keygen_if.sv
// -----------------------------------------------------------------------------
// des_lfsr_keygen_if
//   Bundle between the key-load controller and the LFSR round-key generator,
//   including the generator's write port into the round-key storage RAM.
//
//   master : the controller side (drives load_key/key_in, watches status and
//            the storage write strobe).
//   slave  : the generator side (des_lfsr_keygen).
//
//   Signals
//     load_key   single-cycle regenerate request
//     key_in     64-bit user key, sampled on the accepting edge
//     busy       generation in progress
//     keys_ready all storage entries valid
//     wr_en      storage write strobe, one cycle per key
//     wr_addr    storage address
//     wr_data    round key
// -----------------------------------------------------------------------------
interface des_lfsr_keygen_if #(
  parameter int KEY_W  = 48,
  parameter int ADDR_W = 3
) ();

  logic              load_key;
  logic [63:0]       key_in;
  logic              busy;
  logic              keys_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [KEY_W-1:0]  wr_data;

  modport master (
    output load_key,
    output key_in,
    input  busy,
    input  keys_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  load_key,
    input  key_in,
    output busy,
    output keys_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

endinterface

// File: rtl/des_lfsr_keygen.sv
// -----------------------------------------------------------------------------
// des_lfsr_keygen
//   LFSR-based round-key generator feeding the DES core's round-key storage.
//   On an accepted load request it folds the 64-bit user key into a 48-bit
//   seed, then steps a maximal-length 48-bit Fibonacci LFSR
//   (x^48 + x^47 + x^21 + x^20 + 1). After every STEPS shifts the LFSR state
//   is written to storage, for NUM_KEYS keys at addresses 0..NUM_KEYS-1.
//
//   Ports
//     clk   system clock, rising edge
//     rst   asynchronous, active-high reset
//     kif   des_lfsr_keygen_if.slave
//             load_key/key_in in; busy, keys_ready, wr_en, wr_addr, wr_data out
//
//   Parameters
//     KEY_W     LFSR / round-key width; must stay 48 (taps are fixed)
//     NUM_KEYS  number of round keys written
//     ADDR_W    storage address width, equal to clog2(NUM_KEYS)
//     STEPS     LFSR shifts between consecutive keys, >= 1
//
//   Timing from the edge E0 that accepts load_key:
//     busy high from E0; seed loaded at E1; key k is presented (wr_en high)
//     for the cycle starting at E(1+(k+1)*STEPS+k); keys_ready rises and busy
//     falls at E(1+NUM_KEYS*(STEPS+1)). load_key is ignored while busy.
// -----------------------------------------------------------------------------
module des_lfsr_keygen #(
  parameter int KEY_W    = 48,
  parameter int NUM_KEYS = 8,
  parameter int ADDR_W   = 3,
  parameter int STEPS    = 8
) (
  input  logic             clk,
  input  logic             rst,
  des_lfsr_keygen_if.slave kif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEED  = 3'd1;
  localparam logic [2:0] S_STEP  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_READY = 3'd4;

  // Wide enough to hold STEPS itself so the increment on the last shift
  // never wraps, even when STEPS is a power of two.
  localparam int CNT_W = $clog2(STEPS + 1);

  localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'(STEPS - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(NUM_KEYS - 1);

  // Fold the user key into the seed; an all-zero seed would lock the LFSR,
  // so it is replaced by 1.
  function automatic logic [KEY_W-1:0] seed_of(input logic [63:0] key);
    logic [KEY_W-1:0] s;
    s = key[63:16] ^ {32'h0, key[15:0]};
    if (s == '0) begin
      s = KEY_W'(1);
    end
    return s;
  endfunction

  // One Fibonacci shift: feedback from bits 47,46,20,19 enters at bit 0.
  function automatic logic [KEY_W-1:0] lfsr_step(input logic [KEY_W-1:0] q);
    logic fb;
    fb = q[47] ^ q[46] ^ q[20] ^ q[19];
    return {q[KEY_W-2:0], fb};
  endfunction

  logic [2:0]        state_q,    state_d;
  logic [63:0]       key_q,      key_d;
  logic [KEY_W-1:0]  lfsr_q,     lfsr_d;
  logic [CNT_W-1:0]  step_cnt_q, step_cnt_d;
  logic [ADDR_W-1:0] idx_q,      idx_d;
  logic              busy_q,     busy_d;
  logic              ready_q,    ready_d;
  logic              wr_en_q,    wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
  logic [KEY_W-1:0]  wr_data_q,  wr_data_d;

  // Next-state logic. The write-port registers are loaded on the edge that
  // enters WRITE, so wr_en/wr_addr/wr_data come straight from flops and the
  // address/data hold their last values once WRITE is left.
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    lfsr_d     = lfsr_q;
    step_cnt_d = step_cnt_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      S_IDLE, S_READY: begin
        if (kif.load_key) begin
          key_d   = kif.key_in;
          state_d = S_SEED;
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end

      S_SEED: begin
        lfsr_d     = seed_of(key_q);
        step_cnt_d = '0;
        idx_d      = '0;
        state_d    = S_STEP;
      end

      S_STEP: begin
        lfsr_d     = lfsr_step(lfsr_q);
        step_cnt_d = step_cnt_q + CNT_W'(1);
        if (step_cnt_q == STEP_LAST) begin
          state_d   = S_WRITE;
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = lfsr_d;
        end
      end

      S_WRITE: begin
        if (idx_q == IDX_LAST) begin
          state_d = S_READY;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end else begin
          idx_d      = idx_q + ADDR_W'(1);
          step_cnt_d = '0;
          state_d    = S_STEP;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  // Async reset clears everything, so wr_en drops immediately on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      key_q      <= '0;
      lfsr_q     <= '0;
      step_cnt_q <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      lfsr_q     <= lfsr_d;
      step_cnt_q <= step_cnt_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign kif.busy       = busy_q;
  assign kif.keys_ready = ready_q;
  assign kif.wr_en      = wr_en_q;
  assign kif.wr_addr    = wr_addr_q;
  assign kif.wr_data    = wr_data_q;

endmodule

// File: tb/tb_des_lfsr_keygen.sv
`timescale 1ns/100ps
module tb_des_lfsr_keygen;

  logic        clk;
  logic        rst;
  logic        ld;
  logic [63:0] kin;
  logic        sel;

  int checks   = 0;
  int failures = 0;

  logic [47:0] mem [8];

  localparam logic [47:0] TAPS = 48'hC000_0018_0000;

  des_lfsr_keygen_if #(.KEY_W(48), .ADDR_W(3)) kif8 ();
  des_lfsr_keygen_if #(.KEY_W(48), .ADDR_W(3)) kif1 ();

  des_lfsr_keygen #(.KEY_W(48), .NUM_KEYS(8), .ADDR_W(3), .STEPS(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .kif (kif8)
  );

  des_lfsr_keygen #(.KEY_W(48), .NUM_KEYS(8), .ADDR_W(3), .STEPS(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .kif (kif1)
  );

  assign kif8.load_key = ld & ~sel;
  assign kif1.load_key = ld & sel;
  assign kif8.key_in   = kin;
  assign kif1.key_in   = kin;

  wire        m_busy  = sel ? kif1.busy       : kif8.busy;
  wire        m_ready = sel ? kif1.keys_ready : kif8.keys_ready;
  wire        m_wr_en = sel ? kif1.wr_en      : kif8.wr_en;
  wire [2:0]  m_addr  = sel ? kif1.wr_addr    : kif8.wr_addr;
  wire [47:0] m_data  = sel ? kif1.wr_data    : kif8.wr_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Seed rule: fold high 48 bits with low 16, substitute 1 for zero.
  function automatic logic [47:0] ref_seed(input logic [63:0] k);
    logic [47:0] s;
    s = k[63:16] ^ {32'h0, k[15:0]};
    return (s == 48'h0) ? 48'h1 : s;
  endfunction

  // State after n shifts by the polynomial x^48+x^47+x^21+x^20+1.
  function automatic logic [47:0] ref_adv(input logic [47:0] s, input int n);
    logic [47:0] q;
    q = s;
    for (int i = 0; i < n; i++) q = {q[46:0], ^(q & TAPS)};
    return q;
  endfunction

  // One full generation on the selected DUT; optionally pulses load_key
  // during write number poke (which must be ignored).
  task automatic run_gen(input bit use1, input logic [63:0] key, input int poke);
    int          st;
    int          rdy;
    int          nwr;
    logic [47:0] s;
    st  = use1 ? 1 : 8;
    rdy = 1 + 8 * (st + 1);
    s   = ref_seed(key);
    nwr = 0;
    @(negedge clk);
    sel = use1;
    kin = key;
    ld  = 1'b1;
    @(posedge clk);
    #1;
    ld = 1'b0;
    check("busy_e0",  64'(m_busy),  64'd1);
    check("ready_e0", 64'(m_ready), 64'd0);
    check("wren_e0",  64'(m_wr_en), 64'd0);
    for (int cyc = 1; cyc <= rdy + 3; cyc++) begin
      @(posedge clk);
      #1;
      ld = 1'b0;
      check("busy",       64'(m_busy),  64'(cyc < rdy));
      check("keys_ready", 64'(m_ready), 64'(cyc >= rdy));
      if (m_wr_en) begin
        check("wr_cycle", 64'(cyc), 64'(1 + (nwr + 1) * st + nwr));
        check("wr_addr",  64'(m_addr), 64'(nwr));
        check("wr_data",  64'(m_data), 64'(ref_adv(s, (nwr + 1) * st)));
        mem[m_addr] = m_data;
        if (nwr == poke) begin
          ld  = 1'b1;
          kin = ~key;
        end
        nwr++;
      end
    end
    check("wr_count", 64'(nwr), 64'd8);
  endtask

  initial begin
    logic [63:0] rk;
    rst = 1'b1;
    ld  = 1'b0;
    kin = '0;
    sel = 1'b0;
    #3;
    check("rst_busy",   64'(kif8.busy),       64'd0);
    check("rst_ready",  64'(kif8.keys_ready), 64'd0);
    check("rst_wr_en",  64'(kif8.wr_en),      64'd0);
    check("rst_addr",   64'(kif8.wr_addr),    64'd0);
    check("rst_data",   64'(kif8.wr_data),    64'd0);
    check("rst1_ready", 64'(kif1.keys_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Seed 1 from IDLE, with known-answer keys.
    run_gen(1'b0, 64'h0000_0000_0000_0001, -1);
    check("kat_k0", 64'(mem[0]), 64'h0000_0000_0100);
    check("kat_k1", 64'(mem[1]), 64'h0000_0001_0000);
    check("kat_k2", 64'(mem[2]), 64'h0000_0100_0018);

    // Zero seeds, reloaded back-to-back from READY.
    run_gen(1'b0, 64'h0000_0000_0000_0000, -1);
    check("zero_k2", 64'(mem[2]), 64'h0000_0100_0018);
    run_gen(1'b0, 64'h0000_0000_1234_1234, -1);
    check("zfold_k0", 64'(mem[0]), 64'h0000_0000_0100);
    check("zfold_k2", 64'(mem[2]), 64'h0000_0100_0018);

    // Random keys.
    for (int r = 0; r < 3; r++) begin
      rk = {$urandom, $urandom};
      run_gen(1'b0, rk, -1);
      for (int k = 0; k < 8; k++)
        check("mem_rand", 64'(mem[k]), 64'(ref_adv(ref_seed(rk), (k + 1) * 8)));
    end

    // load_key during the 3rd WRITE is ignored.
    rk = {$urandom, $urandom};
    run_gen(1'b0, rk, 2);
    for (int k = 0; k < 8; k++)
      check("mem_poke", 64'(mem[k]), 64'(ref_adv(ref_seed(rk), (k + 1) * 8)));

    // STEPS=1 instance, seed 1: key k = 1 << (k+1), ready at E17.
    run_gen(1'b1, 64'h0000_0000_0000_0001, -1);
    for (int k = 0; k < 8; k++)
      check("s1_mem", 64'(mem[k]), 64'(48'h1 << (k + 1)));

    // Asynchronous reset in the middle of a STEP run.
    @(negedge clk);
    sel = 1'b0;
    kin = {$urandom, $urandom};
    ld  = 1'b1;
    @(posedge clk);
    #1;
    ld = 1'b0;
    repeat (29) @(posedge clk);
    #($urandom_range(2, 7));
    check("pre_rst_busy", 64'(kif8.busy),    64'd1);
    check("pre_rst_addr", 64'(kif8.wr_addr), 64'd2);
    rst = 1'b1;
    #1;
    check("arst_busy",  64'(kif8.busy),       64'd0);
    check("arst_ready", 64'(kif8.keys_ready), 64'd0);
    check("arst_wr_en", 64'(kif8.wr_en),      64'd0);
    check("arst_addr",  64'(kif8.wr_addr),    64'd0);
    check("arst_data",  64'(kif8.wr_data),    64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      check("idle_ready", 64'(kif8.keys_ready), 64'd0);
      check("idle_busy",  64'(kif8.busy),       64'd0);
      check("idle_wr_en", 64'(kif8.wr_en),      64'd0);
    end

    // Recovery after reset.
    rk = {$urandom, $urandom};
    run_gen(1'b0, rk, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
